// File: rtl/eda_visited_pkg.sv
// Shared types and address helpers for the visited-flag map.
package eda_visited_pkg;

  typedef enum logic {
    READY    = 1'b0,
    CLEARING = 1'b1
  } state_t;

  // Row index: everything above the column field.
  function automatic logic [31:0] addr_row(input logic [31:0] addr, input int j_w);
    return addr >> j_w;
  endfunction

  // Column index: the low j_w bits.
  function automatic logic [31:0] addr_col(input logic [31:0] addr, input int j_w);
    return addr & ((32'd1 << j_w) - 32'd1);
  endfunction

endpackage

// File: rtl/eda_addr_check.sv
// Splits one {i,j} address and reports whether it lies inside the image.
module eda_addr_check
  import eda_visited_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int I_WIDTH    = 4,
  parameter int J_WIDTH    = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [I_WIDTH-1:0]    row,
  output logic [J_WIDTH-1:0]    col,
  output logic                  in_range
);

  logic [31:0] row_w, col_w;

  assign row_w    = addr_row(32'(addr), J_WIDTH);
  assign col_w    = addr_col(32'(addr), J_WIDTH);
  assign row      = row_w[I_WIDTH-1:0];
  assign col      = col_w[J_WIDTH-1:0];
  // The range check uses the full-width fields so wide address fields
  // with non-power-of-two dimensions are still caught.
  assign in_range = (row_w < 32'(M)) && (col_w < 32'(N));

endmodule

// File: rtl/eda_visited_map.sv
// Per-pixel visited flags with parallel neighbour query/mark lanes,
// a row-per-cycle clear sweep and a running count of set flags.
module eda_visited_map
  import eda_visited_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int NUM_NB     = 8,
  parameter int I_WIDTH    = $clog2(M),
  parameter int J_WIDTH    = $clog2(N),
  parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH,
  parameter int CNT_WIDTH  = $clog2(M*N+1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear_req,
  output logic                         clear_busy,
  input  logic                         mark_center,
  input  logic [ADDR_WIDTH-1:0]        center_addr,
  input  logic [NUM_NB*ADDR_WIDTH-1:0] nb_addr,
  input  logic [NUM_NB-1:0]            nb_query,
  input  logic [NUM_NB-1:0]            nb_mark,
  output logic [NUM_NB-1:0]            nb_visited,
  output logic                         nb_valid,
  output logic [CNT_WIDTH-1:0]         visited_count,
  output logic                         all_visited
);

  // Port 0 is the centre, port k+1 is neighbour lane k.
  localparam int NP    = NUM_NB + 1;
  localparam int SUM_W = $clog2(NP + 1);
  localparam logic [CNT_WIDTH:0]   FULL     = (CNT_WIDTH+1)'(M*N);
  localparam logic [I_WIDTH-1:0]   LAST_ROW = I_WIDTH'(M-1);

  state_t                          state, state_next;
  logic [I_WIDTH-1:0]              row, row_next;
  logic [M-1:0][N-1:0]             flags;

  logic [NP-1:0][ADDR_WIDTH-1:0]   addr_all;
  logic [NP-1:0][I_WIDTH-1:0]      row_all;
  logic [NP-1:0][J_WIDTH-1:0]      col_all;
  logic [NP-1:0]                   in_rng, mark_all, mark_ok, cur_flag, fresh;
  logic                            accept;
  logic [SUM_W-1:0]                new_cnt;
  logic [CNT_WIDTH:0]              cnt_sum;
  logic [CNT_WIDTH-1:0]            cnt_next;
  logic [NUM_NB-1:0]               q_res;

  assign addr_all   = {nb_addr, center_addr};
  assign mark_all   = {nb_mark, mark_center};
  assign clear_busy = (state == CLEARING);
  // A clear request in the same cycle pre-empts any marks or queries.
  assign accept     = (state == READY) && !clear_req;

  for (genvar p = 0; p < NP; p++) begin : g_port
    eda_addr_check #(
      .M(M), .N(N), .I_WIDTH(I_WIDTH), .J_WIDTH(J_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_chk (
      .addr    (addr_all[p]),
      .row     (row_all[p]),
      .col     (col_all[p]),
      .in_range(in_rng[p])
    );
    assign cur_flag[p] = in_rng[p] && flags[row_all[p]][col_all[p]];
    assign mark_ok[p]  = accept && mark_all[p] && in_rng[p];
  end

  // Out-of-range neighbours read as visited so the border is never pushed.
  for (genvar k = 0; k < NUM_NB; k++) begin : g_query
    assign q_res[k] = accept && nb_query[k] && (in_rng[k+1] ? cur_flag[k+1] : 1'b1);
  end

  // A mark counts only if its flag is clear and no lower port marks the same address.
  always_comb begin
    fresh = mark_ok & ~cur_flag;
    for (int p = 1; p < NP; p++)
      for (int q = 0; q < NP; q++)
        if (q < p && mark_ok[q] && addr_all[q] == addr_all[p]) fresh[p] = 1'b0;
  end

  // Population count of newly set flags, then saturating add.
  always_comb begin
    new_cnt = '0;
    for (int p = 0; p < NP; p++) new_cnt = new_cnt + SUM_W'(fresh[p]);
    cnt_sum  = {1'b0, visited_count} + (CNT_WIDTH+1)'(new_cnt);
    cnt_next = (cnt_sum > FULL) ? FULL[CNT_WIDTH-1:0] : cnt_sum[CNT_WIDTH-1:0];
  end

  // Next-state logic: READY -> CLEARING on request, one row per cycle back to READY.
  always_comb begin
    state_next = state;
    row_next   = row;
    case (state)
      READY: if (clear_req) begin
        state_next = CLEARING;
        row_next   = '0;
      end
      CLEARING: if (row == LAST_ROW) begin
        state_next = READY;
        row_next   = '0;
      end else begin
        row_next = row + 1'b1;
      end
      default: begin
        state_next = READY;
        row_next   = '0;
      end
    endcase
  end

  // State and sweep row register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= READY;
      row   <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
    end
  end

  // Flag array: row wipe while clearing, otherwise set every accepted mark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
    end else if (state == CLEARING) begin
      flags[row] <= '0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (mark_ok[p]) flags[row_all[p]][col_all[p]] <= 1'b1;
    end
  end

  // Registered query results, sampled before this edge's marks land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nb_visited <= '0;
      nb_valid   <= 1'b0;
    end else begin
      nb_visited <= q_res;
      nb_valid   <= accept && (|nb_query);
    end
  end

  // Visited count and full flag, zeroed when a clear is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      visited_count <= '0;
      all_visited   <= 1'b0;
    end else if (state == READY && clear_req) begin
      visited_count <= '0;
      all_visited   <= 1'b0;
    end else if (accept) begin
      visited_count <= cnt_next;
      all_visited   <= ({1'b0, cnt_next} == FULL);
    end
  end

endmodule

// File: tb/tb_eda_visited_map.sv
// Directed bench: 16x16 map plus a 12x16 map sharing the same stimulus.
module tb_eda_visited_map;

  localparam int NB = 8;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clear_req;
  logic            mark_center;
  logic [AW-1:0]   center_addr;
  logic [NB*AW-1:0] nb_addr;
  logic [NB-1:0]   nb_query, nb_mark;

  logic            busy_a, valid_a, allv_a;
  logic [NB-1:0]   vis_a;
  logic [8:0]      cnt_a;
  logic            busy_b, valid_b, allv_b;
  logic [NB-1:0]   vis_b;
  logic [7:0]      cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eda_visited_map #(.M(16), .N(16), .NUM_NB(NB)) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy_a),
    .mark_center(mark_center), .center_addr(center_addr), .nb_addr(nb_addr),
    .nb_query(nb_query), .nb_mark(nb_mark), .nb_visited(vis_a), .nb_valid(valid_a),
    .visited_count(cnt_a), .all_visited(allv_a)
  );

  eda_visited_map #(.M(12), .N(16), .NUM_NB(NB)) dut12 (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy_b),
    .mark_center(mark_center), .center_addr(center_addr), .nb_addr(nb_addr),
    .nb_query(nb_query), .nb_mark(nb_mark), .nb_visited(vis_b), .nb_valid(valid_b),
    .visited_count(cnt_b), .all_visited(allv_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_req = 0; mark_center = 0; nb_query = '0; nb_mark = '0;
  endtask

  task automatic set_lane(input int k, input logic [AW-1:0] a);
    nb_addr[k*AW +: AW] = a;
  endtask

  int n;
  logic any_v;
  logic [NB-1:0] acc;

  initial begin
    reset_n = 0; center_addr = '0; nb_addr = '0;
    idle();
    #2;
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_vis",   32'(vis_a), 0);
    chk("rst_cnt",   32'(cnt_a), 0);
    chk("rst_busy",  32'(busy_a), 0);
    chk("rst_allv",  32'(allv_a), 0);
    tick(); tick();
    reset_n = 1;
    tick();

    // Query all lanes on a fresh map
    for (int k = 0; k < NB; k++) set_lane(k, AW'(k));
    nb_query = '1;
    tick();
    chk("q8_valid", 32'(valid_a), 1);
    chk("q8_vis",   32'(vis_a), 0);
    chk("q8_cnt",   32'(cnt_a), 0);
    idle(); tick();
    chk("idle_valid", 32'(valid_a), 0);

    // Centre mark then lane query
    mark_center = 1; center_addr = 8'h11;
    tick();
    idle(); nb_query = 8'h01; set_lane(0, 8'h11);
    tick();
    chk("ctr_vis", 32'(vis_a), 32'h01);
    chk("ctr_cnt", 32'(cnt_a), 1);

    // Same-cycle query and mark: old value returned
    idle(); set_lane(0, 8'h22); nb_query = 8'h01; nb_mark = 8'h01;
    tick();
    chk("same_vis", 32'(vis_a), 0);
    chk("same_cnt", 32'(cnt_a), 2);
    nb_mark = '0;
    tick();
    chk("after_vis", 32'(vis_a), 32'h01);

    // Three ports marking one address count once
    idle(); mark_center = 1; center_addr = 8'h33;
    set_lane(0, 8'h33); set_lane(3, 8'h33); nb_mark = 8'h09;
    tick();
    chk("dup_cnt", 32'(cnt_a), 3);

    // Out-of-range row on the 12-row map
    idle(); set_lane(0, 8'hC0); nb_query = 8'h01;
    tick();
    chk("oor_vis12", 32'(vis_b), 32'h01);
    chk("inr_vis16", 32'(vis_a), 0);
    nb_query = '0; nb_mark = 8'h01;
    tick();
    chk("oor_cnt12", 32'(cnt_b), 3);
    chk("inr_cnt16", 32'(cnt_a), 4);

    // Fill the whole 16x16 map
    idle(); nb_mark = '1;
    for (int c = 0; c < 32; c++) begin
      for (int k = 0; k < NB; k++) set_lane(k, AW'(c*NB + k));
      tick();
      if (c == 30) begin
        chk("fill30_cnt",  32'(cnt_a), 248);
        chk("fill30_allv", 32'(allv_a), 0);
      end
    end
    chk("full_cnt",  32'(cnt_a), 256);
    chk("full_allv", 32'(allv_a), 1);

    // Clear sweep; the accepting cycle's mark and all sweep marks are dropped
    idle(); clear_req = 1; mark_center = 1; center_addr = 8'h55;
    tick();
    idle();
    chk("clr_busy", 32'(busy_a), 1);
    chk("clr_cnt",  32'(cnt_a), 0);
    chk("clr_allv", 32'(allv_a), 0);
    for (int k = 0; k < NB; k++) set_lane(k, AW'(8'hF0 + k));
    nb_mark = '1; nb_query = '1;
    n = 0; any_v = 0;
    while (busy_a && n < 40) begin
      n++;
      tick();
      any_v |= valid_a;
    end
    chk("busy_len", 32'(n), 16);
    chk("sweep_valid", 32'(any_v), 0);
    idle();
    chk("sweep_cnt", 32'(cnt_a), 0);
    acc = '0;
    nb_query = '1;
    for (int c = 0; c < 32; c++) begin
      for (int k = 0; k < NB; k++) set_lane(k, AW'(c*NB + k));
      tick();
      acc |= vis_a;
    end
    chk("post_valid", 32'(valid_a), 1);
    chk("post_flags", 32'(acc), 0);
    chk("post_cnt",   32'(cnt_a), 0);

    // Reset in the middle of a sweep
    idle();
    for (int k = 0; k < NB; k++) set_lane(k, AW'(8'hA0 + k));
    nb_mark = '1;
    tick();
    chk("row10_cnt", 32'(cnt_a), 8);
    idle(); clear_req = 1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy", 32'(busy_a), 1);
    reset_n = 0;
    #1;
    chk("ar_busy",  32'(busy_a), 0);
    chk("ar_cnt",   32'(cnt_a), 0);
    chk("ar_valid", 32'(valid_a), 0);
    chk("ar_vis",   32'(vis_a), 0);
    chk("ar_allv",  32'(allv_a), 0);
    tick();
    reset_n = 1;
    tick();
    chk("rel_busy", 32'(busy_a), 0);
    nb_query = '1;
    tick();
    chk("rel_valid", 32'(valid_a), 1);
    chk("rel_vis",   32'(vis_a), 0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
